// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core among NUM_REQ byte-stream requesters.
// Optional per-grant header byte (8'hA0 | owner) is enabled by defining UART_ARB_HDR_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 4,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 grant_active
);

  localparam int              IDX_W     = $clog2(NUM_REQ);
  localparam logic [7:0]      STALL_MAX = 8'(STALL_TIMEOUT);
  localparam logic [3:0]      BURST_MAX = 4'(MAX_BURST - 1);
  localparam logic [7:0]      HDR_BASE  = 8'hA0;

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef UART_ARB_HDR_EN
    S_HDR,
`endif
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [3:0]         burst_q, burst_d;
  logic [7:0]         stall_q, stall_d;
  logic               last_q, last_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
`ifdef UART_ARB_HDR_EN
  logic               hdr_q, hdr_d;
`endif

  logic [NUM_REQ-1:0][7:0] req_bytes;
  logic                    rr_found;
  logic [IDX_W-1:0]        rr_sel;
  logic [IDX_W-1:0]        cand;

  assign req_bytes = req_data;

  // First valid requester searching upward from the one after the last owner.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = last_grant_q;
    cand     = last_grant_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_grant_q) + i) % NUM_REQ);
      if (!rr_found && req_valid[cand]) begin
        rr_found = 1'b1;
        rr_sel   = cand;
      end
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    burst_d      = burst_q;
    stall_d      = stall_q;
    last_d       = last_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    req_ready_d  = '0;
`ifdef UART_ARB_HDR_EN
    hdr_d        = hdr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          owner_d = rr_sel;
          grant_d = NUM_REQ'(1) << rr_sel;
          burst_d = '0;
          stall_d = '0;
`ifdef UART_ARB_HDR_EN
          state_d = S_HDR;
`else
          state_d = S_LOAD;
`endif
        end
      end

`ifdef UART_ARB_HDR_EN
      S_HDR: begin
        if (!tx_busy) begin
          tx_data_d  = HDR_BASE | {{(8-IDX_W){1'b0}}, owner_q};
          tx_start_d = 1'b1;
          hdr_d      = 1'b1;
          state_d    = S_WAIT_BUSY;
        end
      end
`endif

      S_LOAD: begin
        if (!tx_busy && req_valid[owner_q]) begin
          tx_data_d            = req_bytes[owner_q];
          tx_start_d           = 1'b1;
          req_ready_d[owner_q] = 1'b1;
          last_d               = req_last[owner_q];
          state_d              = S_WAIT_BUSY;
        end else if (!req_valid[owner_q]) begin
          // The owner has been idle too long: reclaim the transmitter.
          if (stall_q == STALL_MAX) begin
            last_grant_d = owner_q;
            grant_d      = '0;
            state_d      = S_IDLE;
          end else begin
            stall_d = stall_q + 8'd1;
          end
        end
      end

      S_WAIT_BUSY: begin
        if (tx_busy) state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef UART_ARB_HDR_EN
          if (hdr_q) begin
            hdr_d   = 1'b0;
            stall_d = '0;
            state_d = S_LOAD;
          end else
`endif
          if (last_q || burst_q == BURST_MAX) begin
            last_grant_d = owner_q;
            grant_d      = '0;
            state_d      = S_IDLE;
          end else begin
            burst_d = burst_q + 4'd1;
            stall_d = '0;
            state_d = S_LOAD;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_q      <= '0;
      burst_q      <= '0;
      stall_q      <= '0;
      last_q       <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      req_ready_q  <= '0;
`ifdef UART_ARB_HDR_EN
      hdr_q        <= 1'b0;
`endif
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      burst_q      <= burst_d;
      stall_q      <= stall_d;
      last_q       <= last_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      req_ready_q  <= req_ready_d;
`ifdef UART_ARB_HDR_EN
      hdr_q        <= hdr_d;
`endif
    end
  end

  assign req_ready    = req_ready_q;
  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign grant        = grant_q;
  assign grant_active = |grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART TX core and requester sources.
// Header expectations follow UART_ARB_HDR_EN when it is defined for the build.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int MAX_BURST     = 4;
  localparam int STALL_TIMEOUT = 255;
  localparam int FRAME         = 5;
`ifdef UART_ARB_HDR_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic [NUM_REQ-1:0]   grant;
  logic                 grant_active;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .STALL_TIMEOUT(STALL_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant(grant), .grant_active(grant_active)
  );

  // Requester sources: a byte table per requester, advanced by its req_ready pulse.
  logic [7:0]         mem [NUM_REQ][32];
  int                 len [NUM_REQ];
  int                 last_idx [NUM_REQ];
  int                 ptr [NUM_REQ];
  logic [NUM_REQ-1:0] en, hold;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]      = en[i] && !hold[i] && (ptr[i] < len[i]);
      req_data[8*i +: 8] = mem[i][ptr[i][4:0]];
      req_last[i]       = (ptr[i] == last_idx[i]);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) ptr[i] = 0;
      else if (req_ready[i]) ptr[i] = ptr[i] + 1;
    end
  end

  // TX core: busy rises the cycle after tx_start and holds for FRAME cycles.
  logic tx_pend;
  int   frame_left;
  always @(negedge clk) begin
    if (rst) begin
      tx_busy = 1'b0; tx_pend = 1'b0; frame_left = 0;
    end else if (tx_pend) begin
      tx_pend = 1'b0; tx_busy = 1'b1; frame_left = FRAME - 1;
    end else if (tx_busy) begin
      if (frame_left == 0) tx_busy = 1'b0;
      else frame_left = frame_left - 1;
    end else if (tx_start) begin
      tx_pend = 1'b1;
    end
  end

  // Observers
  logic [7:0]         data_log[$];
  logic [7:0]         all_log[$];
  logic [NUM_REQ-1:0] own_log[$];
  logic [NUM_REQ-1:0] grant_log[$];
  logic [NUM_REQ-1:0] prev_grant;
  int                 rdy_cnt [NUM_REQ];
  int                 stray;

  always @(negedge clk) begin
    if (rst) begin
      data_log.delete(); all_log.delete(); own_log.delete(); grant_log.delete();
      prev_grant = '0; stray = 0;
      for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] = 0;
    end else begin
      if (tx_start) begin
        all_log.push_back(tx_data);
        if (req_ready != '0) begin
          data_log.push_back(tx_data);
          own_log.push_back(grant);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) rdy_cnt[i] = rdy_cnt[i] + 1;
      if ((req_ready & ~grant) != '0) stray = stray + 1;
      if (grant != prev_grant && grant != '0) grant_log.push_back(grant);
      prev_grant = grant;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en   = '0;
    hold = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      len[i] = 0;
      last_idx[i] = -1;
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_log(input int n, input string tag);
    int c = 0;
    while (data_log.size() < n && c < 3000) begin
      tick();
      c++;
    end
    check(tag, (data_log.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_release(input string tag);
    int c = 0;
    while (grant != '0 && c < 3000) begin
      tick();
      c++;
    end
    check(tag, 32'(grant), 32'd0);
  endtask

  initial begin
    int c;
    int g;
    int idx;
    rst  = 1'b1;
    en   = '0;
    hold = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      len[i] = 0;
      last_idx[i] = -1;
      for (int k = 0; k < 32; k++) mem[i][k] = 8'h00;
    end
    tick();
    tick();

    // Reset state
    check("rst_grant",        32'(grant),        32'd0);
    check("rst_grant_active", 32'(grant_active), 32'd0);
    check("rst_tx_start",     32'(tx_start),     32'd0);
    check("rst_req_ready",    32'(req_ready),    32'd0);
    check("rst_tx_data",      32'(tx_data),      32'h00);
    rst = 1'b0;
    tick();

    // Single requester 1, three bytes, last on the third
    mem[1][0] = 8'h11; mem[1][1] = 8'h22; mem[1][2] = 8'h33;
    len[1] = 3; last_idx[1] = 2; en[1] = 1'b1;
    tick();
    check("t1_grant_latency", 32'(grant),        32'b0010);
    check("t1_grant_active",  32'(grant_active), 32'd1);
    wait_log(3, "t1_bytes_seen");
    wait_release("t1_release");
    check("t1_byte0",     32'(data_log[0]), 32'h11);
    check("t1_byte1",     32'(data_log[1]), 32'h22);
    check("t1_byte2",     32'(data_log[2]), 32'h33);
    check("t1_owner",     32'(own_log[2]),  32'b0010);
    check("t1_ready1",    32'(rdy_cnt[1]),  32'd3);
    check("t1_ready_oth", 32'(rdy_cnt[0] + rdy_cnt[2] + rdy_cnt[3]), 32'd0);
    check("t1_starts",    32'(all_log.size()), 32'(3 + HDR_BYTES));
    check("t1_grants",    32'(grant_log.size()), 32'd1);

    // Burst limit without last: release, one IDLE cycle, regrant of the lone requester
    do_reset();
    for (int k = 0; k < 6; k++) mem[1][k] = 8'(8'h40 + k);
    len[1] = 6; last_idx[1] = 5; en[1] = 1'b1;
    wait_log(4, "t6_first_burst");
    wait_release("t6_burst_release");
    c = 0;
    while (grant == '0 && c < 50) begin
      tick();
      c++;
    end
    check("t6_idle_gap",  32'(c),     32'd1);
    check("t6_regrant",   32'(grant), 32'b0010);
    wait_log(6, "t6_second_burst");
    wait_release("t6_final_release");
    check("t6_byte3",     32'(data_log[3]), 32'h43);
    check("t6_byte4",     32'(data_log[4]), 32'h44);
    check("t6_grants",    32'(grant_log.size()), 32'd2);

    // Requesters 0 and 2 continuously valid: alternating 4-byte grants
    do_reset();
    for (int k = 0; k < 16; k++) begin
      mem[0][k] = 8'(k);
      mem[2][k] = 8'(8'h20 + k);
    end
    len[0] = 16; len[2] = 16; en = 4'b0101;
    wait_log(16, "t2_bytes_seen");
    check("t2_grant0", 32'(grant_log[0]), 32'b0001);
    check("t2_grant1", 32'(grant_log[1]), 32'b0100);
    check("t2_grant2", 32'(grant_log[2]), 32'b0001);
    check("t2_grant3", 32'(grant_log[3]), 32'b0100);
    for (int k = 0; k < 16; k++) begin
      g   = k / 4;
      idx = (g / 2) * 4 + (k % 4);
      if (g % 2 == 0) begin
        check($sformatf("t2_byte%0d", k),  32'(data_log[k]), 32'(idx));
        check($sformatf("t2_owner%0d", k), 32'(own_log[k]),  32'b0001);
      end else begin
        check($sformatf("t2_byte%0d", k),  32'(data_log[k]), 32'(8'h20 + idx));
        check($sformatf("t2_owner%0d", k), 32'(own_log[k]),  32'b0100);
      end
    end
    check("t2_stray_ready", 32'(stray), 32'd0);

    // All four requesters at once after reset: order 0,1,2,3
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      mem[i][0] = 8'(8'hC0 + i);
      len[i] = 1; last_idx[i] = 0;
    end
    en = 4'b1111;
    wait_log(4, "t3_bytes_seen");
    wait_release("t3_release");
    check("t3_grants", 32'(grant_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_grant%0d", k), 32'(grant_log[k]), 32'(1 << k));
      check($sformatf("t3_byte%0d", k),  32'(data_log[k]),  32'(8'hC0 + k));
    end
    check("t3_stray_ready", 32'(stray), 32'd0);

    // Requester 3 stalls after grant: reclaimed on the STALL_TIMEOUT count
    do_reset();
    mem[3][0] = 8'h77; len[3] = 1; last_idx[3] = 0; en[3] = 1'b1;
    tick();
    check("t4_grant", 32'(grant), 32'b1000);
    hold[3] = 1'b1;
    c = 0;
    while (grant != '0 && c < 800) begin
      tick();
      c++;
    end
    check("t4_released", 32'(grant), 32'd0);
`ifndef UART_ARB_HDR_EN
    check("t4_grant_cycles", 32'(c), 32'(STALL_TIMEOUT + 1));
`endif
    check("t4_no_data",   32'(data_log.size()), 32'd0);
    check("t4_starts",    32'(all_log.size()),  32'(HDR_BYTES));
    check("t4_no_ready3", 32'(rdy_cnt[3]),      32'd0);
    hold[3] = 1'b0;
    mem[0][0] = 8'h0B; len[0] = 1; last_idx[0] = 0; en[0] = 1'b1;
    tick();
    check("t4_rr_after_3", 32'(grant), 32'b0001);

    // Reset during WAIT_DONE, then requester 0 wins the next arbitration
    do_reset();
    mem[2][0] = 8'h5A; len[2] = 1; last_idx[2] = 0; en[2] = 1'b1;
    wait_log(1, "t5_first_grant");
    wait_release("t5_first_release");
    mem[1][0] = 8'h31; mem[1][1] = 8'h32; len[1] = 2; en[1] = 1'b1;
    c = 0;
    while (tx_busy !== 1'b1 && c < 200) begin
      tick();
      c++;
    end
    check("t5_busy_seen", 32'(tx_busy), 32'd1);
    tick();
    check("t5_pre_grant",   32'(grant),   32'b0010);
    check("t5_pre_tx_data", 32'(tx_data), 32'h31);
    rst = 1'b1;
    #1;
    check("t5_rst_grant",        32'(grant),        32'd0);
    check("t5_rst_grant_active", 32'(grant_active), 32'd0);
    check("t5_rst_tx_start",     32'(tx_start),     32'd0);
    check("t5_rst_req_ready",    32'(req_ready),    32'd0);
    check("t5_rst_tx_data",      32'(tx_data),      32'h00);
    do_reset();
    mem[0][0] = 8'h0A; mem[3][0] = 8'h3A;
    len[0] = 1; len[3] = 1; last_idx[0] = 0; last_idx[3] = 0;
    en = 4'b1001;
    tick();
    check("t5_rr_restart", 32'(grant), 32'b0001);

`ifdef UART_ARB_HDR_EN
    // Header byte precedes the payload of requester 2
    do_reset();
    mem[2][0] = 8'h5C; len[2] = 1; last_idx[2] = 0; en[2] = 1'b1;
    wait_log(1, "th_bytes_seen");
    wait_release("th_release");
    check("th_starts", 32'(all_log.size()), 32'd2);
    check("th_hdr",    32'(all_log[0]),     32'hA2);
    check("th_byte",   32'(all_log[1]),     32'h5C);
    check("th_ready2", 32'(rdy_cnt[2]),     32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte-stream requesters. It sits between the requesters and the UART TX core's `tx_data`/`tx_start`/`tx_busy` interface. It grants the transmitter to one requester at a time for a bounded burst, paces bytes against `tx_busy`, and reclaims the grant from requesters that stall.

## Interface
- `NUM_REQ`, 4, number of requesters (2..4).
- `MAX_BURST`, 4, maximum payload bytes per grant (1..15).
- `STALL_TIMEOUT`, 255, maximum cycles a granted requester may hold `req_valid` low in LOAD before losing its grant (1..255).

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NUM_REQ  requester i has a byte pending
- `req_data`  in  8*NUM_REQ  requester i byte on `[8i+7:8i]`
- `req_last`  in  NUM_REQ  requester i byte is the final byte of its message
- `req_ready`  out  NUM_REQ  one-cycle pulse: byte of requester i consumed
- `tx_data`  out  8  byte to UART TX core
- `tx_start`  out  1  one-cycle start pulse to UART TX core
- `tx_busy`  in  1  UART TX core busy
- `grant`  out  NUM_REQ  one-hot current owner, all zero when idle
- `grant_active`  out  1  OR of `grant`

## Operation
- FSM states: IDLE, HDR (only with macro), LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE: if any `req_valid` is set, select the first set bit, searching upward from `(last_grant+1) mod NUM_REQ`.
  - On selection, set `grant`, clear `burst_cnt` and `stall_cnt`, and go to HDR or LOAD.
  - `last_grant` resets to `NUM_REQ-1`, so requester 0 wins first.
- LOAD, with owner g:
  - If `tx_busy`=0 and `req_valid[g]`=1: register `tx_data`=`req_data[g]`, pulse `tx_start` and `req_ready[g]` together for one cycle, latch `req_last[g]` into `last_q`, and go to WAIT_BUSY.
  - If `req_valid[g]`=0: increment `stall_cnt`. At `stall_cnt`=`STALL_TIMEOUT`, release.
  - `stall_cnt` clears on each LOAD entry.
- WAIT_BUSY: wait for `tx_busy`=1, then go to WAIT_DONE. The TX core raises busy on the cycle after `tx_start`.
- WAIT_DONE: wait for `tx_busy`=0. Then:
  - After a header, go to LOAD.
  - Else, if `last_q`=1 or `burst_cnt`=`MAX_BURST-1`, release.
  - Else increment `burst_cnt` and go to LOAD.
- Release: set `last_grant`=g, clear `grant`, go to IDLE. Re-arbitration always costs one IDLE cycle.
- Non-owner `req_ready` bits stay 0. `req_valid` of non-owners is ignored until release.
- A requester must hold `req_data`/`req_last` stable until its `req_ready` pulse, and advance on the following cycle.
- `req_valid` changes on non-owners mid-grant have no effect.
- A `req_valid` that deasserts after acceptance does not abort the burst. The arbiter returns to LOAD and waits or times out.

## Timing
- Reset values: `req_ready`=0, `tx_data`=8'h00, `tx_start`=0, `grant`=0, `grant_active`=0. FSM=IDLE, `last_grant`=`NUM_REQ-1`, all counters 0.
- Reset mid-frame aborts immediately with no completion pulse. The TX core shares the same `rst`.
- Grant latency: `grant` is visible 1 cycle after `req_valid` is sampled in IDLE.
- Byte issue: `tx_start`/`req_ready` appear 1 cycle after the LOAD condition is met. Both are high for exactly 1 cycle.
- Minimum byte-to-byte spacing equals the TX core frame time plus 2 cycles.
- Simultaneous requests are resolved purely by the round-robin pointer. The same requester is never granted twice in a row while another requester is valid in IDLE.
- Burst limit reached with `last_q`=0: the grant is released, and the same requester may be regranted after one IDLE cycle if it is alone.

## Configuration
- `UART_ARB_HDR_EN` defined:
  - After each grant, HDR waits for `tx_busy`=0, then sends header byte `8'hA0 | g` (pulses `tx_start`, no `req_ready`).
  - HDR then passes through WAIT_BUSY/WAIT_DONE to LOAD.
  - The header does not count toward `MAX_BURST`.
  - A requester that times out still has its header sent.
- Undefined: the HDR state and its logic are absent. IDLE goes directly to LOAD.

## Test plan
- Single requester 1, 3 bytes 8'h11/8'h22/8'h33, last on the third: three `tx_start` pulses with those bytes, three `req_ready[1]` pulses, `grant`=4'b0010, then `grant`=0.
- Requesters 0 and 2 valid continuously with `MAX_BURST`=4 and no last: grants alternate 0,2,0,2, with 4 bytes per grant.
- All four requesters valid at once after reset: grant order 0,1,2,3.
- Requester 3 granted, then holds `req_valid` low: grant released exactly at `stall_cnt`=255, with no `tx_start` issued.
- `rst` pulsed during WAIT_DONE: all outputs return to reset values on the same edge, and requester 0 wins the next arbitration.
- With `UART_ARB_HDR_EN` defined, requester 2 sends one byte 8'h5C with last: `tx_data` sequence is 8'hA2, then 8'h5C, and exactly one `req_ready[2]` pulse occurs.
